// File: rtl/mmul_parallel_engine_ctrl_pkg.sv
// Purpose: shared types for the mmul_parallel engine-side controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: engine FSM state enum, default field widths, extended ctrl/flags records.
package mmul_parallel_engine_ctrl_pkg;

  localparam int unsigned LEN_W_DEF   = 32;
  localparam int unsigned SHIFT_W_DEF = 5;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_LAUNCH,
    ENG_RUN,
    ENG_DRAIN,
    ENG_DONE
  } state_engine_ctrl_t;

  typedef struct packed {
    logic                   clear;
    logic                   enable;
    logic                   start;
    logic [LEN_W_DEF-1:0]   len;
    logic                   simple_mul;
    logic [SHIFT_W_DEF-1:0] shift;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 ready;
    logic [LEN_W_DEF-1:0] cnt;
    logic                 acc_valid;
    logic                 done;
    logic                 err;
  } flags_engine_t;

endpackage

// File: rtl/mmul_parallel_engine_ctrl_beat_counter.sv
// Purpose: saturating out_r beat counter with enable, clear and terminal (cnt==limit) flag.
// Latency: increment visible on cnt_o one cycle after inc_i; term_o is decoded from the register.
// Backpressure: none; increments at the limit are dropped (saturation).
// Ports: clk_i/rst_i (sync, active-high), clr_i (sync clear, beats enable), en_i, inc_i,
//        limit_i (terminal value), cnt_o (count), term_o (cnt_o == limit_i).
module mmul_parallel_engine_ctrl_beat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == limit_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i && !term_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmul_parallel_engine_ctrl.sv
// Purpose: engine-side responder to the control FSM; launches the kernel (ap_start/ap_ready/ap_done)
//          and counts out_r beats, reporting ready/cnt/acc_valid/done/err.
// Latency: start -> kern_start_o 1 cycle; beat -> cnt_o/acc_valid_o 1 cycle; kern_done (DRAIN) -> done_o 2 cycles.
// Backpressure: out_r is only monitored; enable_i=0 freezes state and drops that cycle's beats/pulses.
// Ports: clk_i, rst_i; ctrl inputs clear/enable/start/len/simple_mul/shift; flags outputs
//        ready/cnt/acc_valid/done/err; kernel handshake kern_*; out_r monitor out_valid_i/out_ready_i.
module mmul_parallel_engine_ctrl
  import mmul_parallel_engine_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               simple_mul_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               ready_o,
  output logic [LEN_W-1:0]   cnt_o,
  output logic               acc_valid_o,
  output logic               done_o,
  output logic               err_o,
  output logic               kern_start_o,
  input  logic               kern_ready_i,
  input  logic               kern_done_i,
  output logic [LEN_W-1:0]   kern_len_o,
  output logic               kern_simple_mul_o,
  output logic [SHIFT_W-1:0] kern_shift_o,
  input  logic               out_valid_i,
  input  logic               out_ready_i
);

  state_engine_ctrl_t state_q;
  logic               ready_q, acc_valid_q, done_q, err_q, kern_start_q, done_seen_q;
  logic [LEN_W-1:0]   kern_len_q;
  logic               kern_simple_mul_q;
  logic [SHIFT_W-1:0] kern_shift_q;

  logic beat, counting, start_acc, cnt_inc, term, last_beat, reached, kdone_any;

  assign beat      = out_valid_i & out_ready_i;
  // Counting starts in LAUNCH so a beat coincident with ap_ready is not lost.
  assign counting  = (state_q == ENG_LAUNCH) || (state_q == ENG_RUN);
  assign start_acc = enable_i && start_i && (state_q == ENG_IDLE);
  assign cnt_inc   = enable_i && beat && counting && !term;
  assign last_beat = cnt_inc && (cnt_o == kern_len_q - LEN_W'(1));
  assign reached   = term || last_beat;
  // An ap_done seen early is remembered so the job can finish on its final beat.
  assign kdone_any = kern_done_i || done_seen_q;

  mmul_parallel_engine_ctrl_beat_counter #(.W(LEN_W)) u_beat_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i || start_acc),
    .en_i    (enable_i),
    .inc_i   (cnt_inc),
    .limit_i (kern_len_q),
    .cnt_o   (cnt_o),
    .term_o  (term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q           <= ENG_IDLE;
      ready_q           <= 1'b1;
      acc_valid_q       <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      kern_start_q      <= 1'b0;
      done_seen_q       <= 1'b0;
      kern_len_q        <= '0;
      kern_simple_mul_q <= 1'b0;
      kern_shift_q      <= '0;
    end else if (!enable_i) begin
      acc_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_valid_q <= cnt_inc;
      done_q      <= 1'b0;
      // Any beat once the count has hit len is an overrun.
      if (beat && term) err_q <= 1'b1;
      case (state_q)
        ENG_IDLE: begin
          if (start_i) begin
            kern_len_q        <= len_i;
            kern_simple_mul_q <= simple_mul_i;
            kern_shift_q      <= shift_i;
            ready_q           <= 1'b0;
            done_seen_q       <= 1'b0;
            if (len_i == '0) begin
              state_q <= ENG_DONE;
            end else begin
              state_q      <= ENG_LAUNCH;
              kern_start_q <= 1'b1;
            end
          end
        end
        ENG_LAUNCH: begin
          if (kern_done_i) done_seen_q <= 1'b1;
          if (kern_ready_i) begin
            kern_start_q <= 1'b0;
            if (reached) state_q <= kdone_any ? ENG_DONE : ENG_DRAIN;
            else         state_q <= ENG_RUN;
          end
        end
        ENG_RUN: begin
          if (kern_done_i) done_seen_q <= 1'b1;
          if (reached) state_q <= kdone_any ? ENG_DONE : ENG_DRAIN;
        end
        ENG_DRAIN: begin
          if (kdone_any) state_q <= ENG_DONE;
        end
        ENG_DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ENG_IDLE;
        end
        default: state_q <= ENG_IDLE;
      endcase
    end
  end

  assign ready_o           = ready_q;
  assign acc_valid_o       = acc_valid_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign kern_start_o      = kern_start_q;
  assign kern_len_o        = kern_len_q;
  assign kern_simple_mul_o = kern_simple_mul_q;
  assign kern_shift_o      = kern_shift_q;

endmodule
